// File: rtl/pipe_stage_reg.sv
// Parameterised pipeline register chain (DEPTH stages) with flush-to-handler,
// stall, bubble insertion and saturating bubble/flush event counters.
module pipe_stage_reg #(
  parameter int          DW         = 128,
  parameter int          DEPTH      = 1,
  parameter int          EXC_W      = 5,
  parameter logic [31:0] HANDLER_PC = 32'h00004180,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic             halt,
  input  logic [31:0]      in_pc,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  input  logic [EXC_W-1:0] in_exc,
  input  logic             in_bd,
  output logic [31:0]      out_pc,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  output logic [EXC_W-1:0] out_exc,
  output logic             out_bd,
  output logic             exc_pending,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0]      r_pc    [DEPTH];
  logic [DW-1:0]    r_data  [DEPTH];
  logic [EXC_W-1:0] r_exc   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_bd;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_exc_pending;
  logic             w_do_halt;

  // Halt only takes effect in a cycle that would otherwise advance.
  assign w_do_halt = halt && !stall && !req;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k]   <= '0;
        r_data[k] <= '0;
        r_exc[k]  <= '0;
      end
      r_valid <= '0;
      r_bd    <= '0;
    end else if (req) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k]   <= HANDLER_PC;
        r_data[k] <= '0;
        r_exc[k]  <= '0;
      end
      r_valid <= '0;
      r_bd    <= '0;
    end else if (!stall) begin
      // A bubble keeps pc/bd so the stage still knows where it is.
      r_pc[0]    <= in_pc;
      r_bd[0]    <= in_bd;
      r_data[0]  <= halt ? '0 : in_data;
      r_valid[0] <= halt ? 1'b0 : in_valid;
      r_exc[0]   <= halt ? '0 : in_exc;
      for (int k = 1; k < DEPTH; k++) begin
        r_pc[k]    <= r_pc[k-1];
        r_bd[k]    <= r_bd[k-1];
        r_data[k]  <= r_data[k-1];
        r_valid[k] <= r_valid[k-1];
        r_exc[k]   <= r_exc[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (req && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_do_halt && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_exc_pending = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      w_exc_pending = w_exc_pending | (r_valid[k] && (r_exc[k] != '0));
  end

  assign exc_pending = w_exc_pending;
  assign out_pc      = r_pc[DEPTH-1];
  assign out_data    = r_data[DEPTH-1];
  assign out_valid   = r_valid[DEPTH-1];
  assign out_exc     = r_exc[DEPTH-1];
  assign out_bd      = r_bd[DEPTH-1];
  assign bubble_cnt  = r_bubble_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
